dm_access: RTL
==============

DM_ACCESS -- requirements
Module: dm_access

Interface
REQ-001 Parameter MAX_WAIT, default 255, cycles in BUS without bus_ready before timeout; legal range 1..255.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 mem_read  in  1  load request from MEM stage; held while stall=1.
REQ-005 mem_write  in  1  store request from MEM stage; held while stall=1.
REQ-006 dm_ctrl  in  3  size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 stall  out  1  freeze pipeline.
REQ-010 rdata  out  32  aligned, extended load result.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 misalign  out  1  one-cycle misaligned-access pulse.
REQ-013 bus_err  out  1  one-cycle timeout pulse.
REQ-014 bus_valid  out  1  bus request.
REQ-015 bus_we  out  1  1 = write.
REQ-016 bus_addr  out  30  word address (addr[31:2]).
REQ-017 bus_be  out  4  byte enables.
REQ-018 bus_wdata  out  32  lane-placed store data.
REQ-019 bus_ready  in  1  bus accepts/completes this cycle.
REQ-020 bus_rdata  in  32  read word, valid when bus_ready=1.

Function
REQ-021 FSM states IDLE, BUS, RESP.
REQ-022 IDLE: (mem_read|mem_write) -> stall=1 combinationally, latch addr/dm_ctrl/lane data/be, go BUS (or RESP if misaligned per REQ-035).
REQ-023 mem_read and mem_write both 1 -> write; read ignored.
REQ-024 dm_ctrl 101..111 -> treated as word.
REQ-025 bus_be: word 1111; half addr[1]=0 -> 0011, 1 -> 1100; byte 0001<<addr[1:0].
REQ-026 bus_wdata: byte/half shifted left by 8*addr[1:0]; word unchanged; unused lanes 0.
REQ-027 BUS: bus_valid=1, stall=1; bus_addr/bus_be/bus_we/bus_wdata stable until bus_ready=1.
REQ-028 BUS & bus_ready: load -> rdata = selected lane, sign/zero-extended per dm_ctrl; store -> rdata unchanged; go RESP.
REQ-029 Wait counter (8 bit) cleared on IDLE->BUS, +1 per BUS cycle with bus_ready=0; reaching MAX_WAIT -> bus_valid drops, rdata=0, bus_err=1 in RESP, go RESP.
REQ-030 RESP: done=1, stall=0, bus_valid=0; next state IDLE unconditionally; requests in RESP ignored.
REQ-031 Latency with bus_ready tied 1: request cycle N, bus handshake N+1, done N+2; stall high N and N+1.
REQ-032 rdata holds last load result until next completed load, timeout, or reset.

Reset
REQ-033 rstn=0 -> state IDLE, counter 0, rdata 0, all outputs 0 immediately (async), regardless of state.
REQ-034 Reset mid-BUS abandons the transaction; no done pulse; bus_valid low during reset.

Configuration
REQ-035 DM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus access, IDLE->RESP, misalign=1 and done=1 in RESP, rdata unchanged.
REQ-036 DM_MISALIGN_TRAP_EN undefined: half ignores addr[0], word ignores addr[1:0]; misalign tied 0.

Verification
REQ-037 Store byte: mem_write=1, dm_ctrl=011, addr=0x103, wdata=0xAB, bus_ready=1 -> bus_addr=0x40, bus_be=1000, bus_wdata=0xAB000000, done at N+2.
REQ-038 Load half signed: addr=0x202, dm_ctrl=001, bus_rdata=0x8001FFFF -> rdata=0xFFFF8001; dm_ctrl=010 -> 0x00008001.
REQ-039 Wait states: bus_ready low 3 cycles then high -> bus signals stable 4 BUS cycles, stall high 5 cycles, single done.
REQ-040 Timeout, MAX_WAIT=4, bus_ready=0 -> bus_valid high 4 cycles, bus_err and done one cycle, rdata=0.
REQ-041 Misaligned word addr=0x6 with macro -> misalign+done, bus_valid never 1; without macro -> bus_addr=0x1, bus_be=1111.
REQ-042 rstn pulsed low in BUS -> bus_valid/stall 0 immediately, no done, next request served normally.

Source files
------------

// File: rtl/dm_access_if.sv
// Word-addressed data-memory bus between the MEM-stage access unit and memory.
// master = access unit (drives request), slave = memory (drives ready/read data).
interface dm_access_if;
    logic        bus_valid;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/dm_access.sv
// MEM-stage data-memory access unit: lane placement, byte enables, load extension, bus timeout.
// Latency: request cycle N, bus handshake N+1 at the earliest, done pulse one cycle after handshake.
// Backpressure: stall held while a request waits in IDLE or BUS; bus waits up to MAX_WAIT cycles.
// Optional misaligned-access trap is enabled by defining DM_MISALIGN_TRAP_EN.
module dm_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   dm_ctrl,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic         stall,
    output logic [31:0]  rdata,
    output logic         done,
    output logic         misalign,
    output logic         bus_err,
    dm_access_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;

    logic        req;
    size_t       req_size;
    logic        req_signed;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_misalign;

    size_t       lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic        lat_we;
    logic [29:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        err_q;
    logic        mis_q;
    logic [31:0] rdata_q;

    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic        timeout;

    assign req = mem_read | mem_write;

    // Request decode: reserved dm_ctrl codes fall back to a word access.
    always_comb begin
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        case (dm_ctrl)
            3'b001: begin req_size = SZ_HALF; req_signed = 1'b1; end
            3'b010: begin req_size = SZ_HALF; req_signed = 1'b0; end
            3'b011: begin req_size = SZ_BYTE; req_signed = 1'b1; end
            3'b100: begin req_size = SZ_BYTE; req_signed = 1'b0; end
            default: begin req_size = SZ_WORD; req_signed = 1'b0; end
        endcase
    end

    // Lane offset, byte enables and store placement; halves use only addr[1].
    always_comb begin
        req_off   = 2'b00;
        req_be    = 4'b1111;
        req_wdata = wdata;
        case (req_size)
            SZ_HALF: begin
                req_off   = {addr[1], 1'b0};
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {16'h0000, wdata[15:0]} << {req_off, 3'b000};
            end
            SZ_BYTE: begin
                req_off   = addr[1:0];
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {24'h000000, wdata[7:0]} << {req_off, 3'b000};
            end
            default: begin
                req_off   = 2'b00;
                req_be    = 4'b1111;
                req_wdata = wdata;
            end
        endcase
    end

`ifdef DM_MISALIGN_TRAP_EN
    assign req_misalign = ((req_size == SZ_HALF) && addr[0]) ||
                          ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    // Load extraction from the latched lane offset.
    assign lane_word = bus.bus_rdata >> {lat_off, 3'b000};

    always_comb begin
        load_val = bus.bus_rdata;
        case (lat_size)
            SZ_BYTE: load_val = {{24{lat_signed & lane_word[7]}},  lane_word[7:0]};
            SZ_HALF: load_val = {{16{lat_signed & lane_word[15]}}, lane_word[15:0]};
            default: load_val = bus.bus_rdata;
        endcase
    end

    assign timeout = !bus.bus_ready && (wait_cnt == WAIT_LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = req_misalign ? S_RESP : S_BUS;
            end
            S_BUS: begin
                if (bus.bus_ready || timeout) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. Stall is gated by reset so it drops immediately on rstn=0.
    always_comb begin
        stall         = 1'b0;
        bus.bus_valid = 1'b0;
        done          = 1'b0;
        misalign      = 1'b0;
        bus_err       = 1'b0;
        case (state)
            S_IDLE: stall = rstn & req;
            S_BUS: begin
                stall         = rstn;
                bus.bus_valid = 1'b1;
            end
            S_RESP: begin
                done     = 1'b1;
                misalign = mis_q;
                bus_err  = err_q;
            end
            default: ;
        endcase
    end

    assign bus.bus_we    = lat_we;
    assign bus.bus_addr  = lat_addr;
    assign bus.bus_be    = lat_be;
    assign bus.bus_wdata = lat_wdata;
    assign rdata         = rdata_q;

    // Request latch, wait counter and load result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_size   <= SZ_WORD;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_we     <= 1'b0;
            lat_addr   <= 30'h0;
            lat_be     <= 4'h0;
            lat_wdata  <= 32'h0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
            wait_cnt   <= 8'h00;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_off;
                        lat_we     <= mem_write;
                        lat_addr   <= addr[31:2];
                        lat_be     <= req_be;
                        lat_wdata  <= req_wdata;
                        err_q      <= 1'b0;
                        mis_q      <= req_misalign;
                        wait_cnt   <= 8'h00;
                    end
                end
                S_BUS: begin
                    if (bus.bus_ready) begin
                        if (!lat_we) rdata_q <= load_val;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h01;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
